// File: rtl/uart_pkg.sv
// Shared types and constants for the camera-path UART transmitter.
package uart_pkg;

    localparam int CLKS_115200_125M = 1085;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_GAP
    } state_t;

    // Even mode makes the total count of ones even; odd mode makes it odd.
    function automatic logic parity_bit(input logic [7:0] d, input int mode);
        return (mode == PAR_EVEN) ? ^d : ~^d;
    endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake and line outputs between frame sequencer and transmitter.
interface uart_byte_tx_if;

    logic       i_Valid;
    logic [7:0] i_Data;
    logic       o_Ready;
    logic       o_Tx;
    logic       o_Busy;
    logic       o_Done;

    modport master (
        output i_Valid, i_Data,
        input  o_Ready, o_Tx, o_Busy, o_Done
    );

    modport slave (
        input  i_Valid, i_Data,
        output o_Ready, o_Tx, o_Busy, o_Done
    );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer; o_Tick marks the last clock of each bit time.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_115200_125M
) (
    input  logic Clk,
    input  logic i_Rst,
    input  logic i_Run,
    output logic o_Tick
);

    localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!i_Run || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_Tick = i_Run && (cnt_q == LAST);

endmodule

// File: rtl/uart_byte_tx.sv
// UART byte transmitter: start, 8 data bits LSB first, optional parity,
// stop bits and an idle gap so the receiver can find byte boundaries.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_115200_125M,
    parameter int PARITY       = PAR_NONE,
    parameter int STOP_BITS    = 1,
    parameter int GAP_BITS     = 1
) (
    input  logic           Clk,
    input  logic           i_Rst,
    uart_byte_tx_if.slave  bus
);

    state_t     state_q;
    logic [7:0] shift_q;
    logic       par_q;
    logic [2:0] bit_q;
    logic       tx_q;
    logic       ready_q;
    logic       busy_q;
    logic       done_q;
    logic       run;
    logic       tick;

    assign run = (state_q != S_IDLE);

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_timer (
        .Clk    (Clk),
        .i_Rst  (i_Rst),
        .i_Run  (run),
        .o_Tick (tick)
    );

    always_ff @(posedge Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            par_q   <= 1'b0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.i_Valid && ready_q) begin
                        shift_q <= bus.i_Data;
                        bit_q   <= '0;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        // Shift register still holds the untouched byte here.
                        par_q   <= parity_bit(shift_q, PARITY);
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                tx_q    <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_q   <= bit_q + 1'b1;
                            tx_q    <= shift_q[1];
                            shift_q <= {1'b0, shift_q[7:1]};
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (bit_q == 3'(STOP_BITS - 1)) begin
                            bit_q <= '0;
                            if (GAP_BITS == 0) begin
                                state_q <= S_IDLE;
                                ready_q <= 1'b1;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= S_GAP;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    if (tick) begin
                        if (bit_q == 3'(GAP_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_Tx    = tx_q;
    assign bus.o_Ready = ready_q;
    assign bus.o_Busy  = busy_q;
    assign bus.o_Done  = done_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: three builds (no parity, even, odd) at 4 clocks per bit.
module tb_uart_byte_tx;

    localparam int C = 4;

    logic       clk;
    logic       rst;
    logic [2:0] vld;
    logic [7:0] d;
    int         sel;
    logic       tx_s, rdy_s, busy_s, done_s;
    int         vectors;
    int         miscompares;

    uart_byte_tx_if if0 ();
    uart_byte_tx_if if1 ();
    uart_byte_tx_if if2 ();

    assign if0.i_Valid = vld[0];
    assign if0.i_Data  = d;
    assign if1.i_Valid = vld[1];
    assign if1.i_Data  = d;
    assign if2.i_Valid = vld[2];
    assign if2.i_Data  = d;

    // no parity, 1 stop, 1 gap: F = 44
    uart_byte_tx #(.CLKS_PER_BIT(C), .PARITY(0), .STOP_BITS(1), .GAP_BITS(1))
        dut0 (.Clk(clk), .i_Rst(rst), .bus(if0));
    // even parity, 2 stop, no gap: F = 48
    uart_byte_tx #(.CLKS_PER_BIT(C), .PARITY(2), .STOP_BITS(2), .GAP_BITS(0))
        dut1 (.Clk(clk), .i_Rst(rst), .bus(if1));
    // odd parity, 1 stop, 3 gap: F = 56
    uart_byte_tx #(.CLKS_PER_BIT(C), .PARITY(1), .STOP_BITS(1), .GAP_BITS(3))
        dut2 (.Clk(clk), .i_Rst(rst), .bus(if2));

    always_comb begin
        tx_s = if0.o_Tx;   rdy_s = if0.o_Ready;
        busy_s = if0.o_Busy; done_s = if0.o_Done;
        case (sel)
            1: begin
                tx_s = if1.o_Tx;   rdy_s = if1.o_Ready;
                busy_s = if1.o_Busy; done_s = if1.o_Done;
            end
            2: begin
                tx_s = if2.o_Tx;   rdy_s = if2.o_Ready;
                busy_s = if2.o_Busy; done_s = if2.o_Done;
            end
            default: ;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents a byte and waits for the accepting edge; valid is left high.
    task automatic accept(input int s, input logic [7:0] b, output int waited);
        logic r;
        sel = s;
        d = b;
        vld[s] = 1'b1;
        waited = 0;
        r = 1'b0;
        for (int i = 0; i < 200 && !r; i++) begin
            r = rdy_s;
            @(posedge clk); #1;
            waited++;
        end
        chk("accept", {31'd0, r}, 32'd1);
        chk("start_tx", {31'd0, tx_s}, 32'd0);
        chk("start_rdy", {31'd0, rdy_s}, 32'd0);
        chk("start_busy", {31'd0, busy_s}, 32'd1);
    endtask

    // Follows a frame cycle by cycle from just after the accept edge to edge k+F.
    task automatic frame_check(input int s, input logic [15:0] fr, input int F,
                               input bit disturb);
        int bad;
        logic [7:0] rx;
        sel = s;
        bad = -1;
        rx = '0;
        for (int t = 1; t < F; t++) begin
            @(posedge clk); #1;
            if (disturb) begin
                if (t == 6)  begin d = 8'hFF; vld[s] = 1'b1; end
                if (t == 14) vld[s] = 1'b0;
                if (t == 22) begin d = 8'h00; vld[s] = 1'b1; end
                if (t == 30) vld[s] = 1'b0;
            end
            if (bad < 0 && (tx_s !== fr[t / C] || done_s !== 1'b0 ||
                            rdy_s !== 1'b0 || busy_s !== 1'b1))
                bad = t;
            if (t % C == C / 2 && t / C >= 1 && t / C <= 8)
                rx[t / C - 1] = tx_s;
        end
        chk("line_first_bad_cycle", bad, -1);
        @(posedge clk); #1;
        chk("end_tx", {31'd0, tx_s}, 32'd1);
        chk("end_done", {31'd0, done_s}, 32'd1);
        chk("end_rdy", {31'd0, rdy_s}, 32'd1);
        chk("end_busy", {31'd0, busy_s}, 32'd0);
        chk("rx_byte", {24'd0, rx}, {24'd0, fr[8:1]});
    endtask

    task automatic done_drop();
        @(posedge clk); #1;
        chk("done_one_cycle", {31'd0, done_s}, 32'd0);
    endtask

    initial begin
        int w;
        int low;
        vectors = 0;
        miscompares = 0;
        sel = 0;
        rst = 1'b1;
        vld = '0;
        d = 8'h00;

        // reset held 3 cycles
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", {31'd0, if0.o_Tx}, 32'd1);
        chk("rst_rdy", {31'd0, if0.o_Ready}, 32'd1);
        chk("rst_busy", {31'd0, if0.o_Busy}, 32'd0);
        chk("rst_done", {31'd0, if0.o_Done}, 32'd0);
        chk("rst_rdy_even", {31'd0, if1.o_Ready}, 32'd1);
        chk("rst_tx_odd", {31'd0, if2.o_Tx}, 32'd1);
        rst = 1'b0;
        low = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (if0.o_Tx !== 1'b1 || if0.o_Busy !== 1'b0) low++;
        end
        chk("idle_line_100", low, 0);

        // 0xA5: 0,1,0,1,0,0,1,0,1,1,1
        accept(0, 8'hA5, w);
        vld[0] = 1'b0;
        frame_check(0, 16'h074A, 44, 1'b0);
        done_drop();

        // even parity 0x07 -> parity 1, two stops
        accept(1, 8'h07, w);
        vld[1] = 1'b0;
        frame_check(1, 16'h0E0E, 48, 1'b0);
        done_drop();

        // odd parity 0x07 -> parity 0; 0x00 -> parity 1
        accept(2, 8'h07, w);
        vld[2] = 1'b0;
        frame_check(2, 16'h3C0E, 56, 1'b0);
        done_drop();
        accept(2, 8'h00, w);
        vld[2] = 1'b0;
        frame_check(2, 16'h3E00, 56, 1'b0);
        done_drop();

        // back-to-back 0x00 then 0xFF with valid held
        accept(0, 8'h00, w);
        frame_check(0, 16'h0600, 44, 1'b0);
        accept(0, 8'hFF, w);
        chk("b2b_wait_cycles", w, 1);
        vld[0] = 1'b0;
        frame_check(0, 16'h07FE, 44, 1'b0);
        done_drop();

        // data/valid churn while busy
        accept(0, 8'h5A, w);
        vld[0] = 1'b0;
        frame_check(0, 16'h06B4, 44, 1'b1);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (tx_s !== 1'b1 || busy_s !== 1'b0) low++;
        end
        chk("no_extra_frame", low, 0);

        // reset during data bit 3, then 0x3C
        accept(0, 8'h00, w);
        vld[0] = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("mid_bit3_tx", {31'd0, tx_s}, 32'd0);
        rst = 1'b1;
        d = 8'h3C;
        vld[0] = 1'b1;
        #1;
        chk("midrst_tx", {31'd0, tx_s}, 32'd1);
        chk("midrst_rdy", {31'd0, rdy_s}, 32'd1);
        chk("midrst_busy", {31'd0, busy_s}, 32'd0);
        chk("midrst_done", {31'd0, done_s}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_no_accept", {30'd0, busy_s, tx_s}, 32'd1);
        rst = 1'b0;
        accept(0, 8'h3C, w);
        chk("post_rst_wait", w, 1);
        vld[0] = 1'b0;
        frame_check(0, 16'h0678, 44, 1'b0);
        done_drop();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_byte_tx.md
# uart_byte_tx

Serial transmitter for the camera frame path. It accepts one byte at a time from the frame sequencer over a valid/ready handshake and drives it onto the UART line as 8 data bits, LSB first, with optional parity. It then adds a configurable idle gap so the microcontroller can detect byte boundaries. It sits directly downstream of the RAM-read sequencer and is the only driver of `o_Tx`.

## Interface
- `CLKS_PER_BIT`, default 1085: `Clk` cycles per bit (125 MHz / 115200). Must be ≥ 2.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.
- `GAP_BITS`, default 1: extra idle-high bit times after the stop bits, 0–3.
- `Clk`, input, 1: the single clock. All logic is in this domain.
- `i_Rst`, input, 1: reset, asynchronous and active-high.
- `i_Valid`, input, 1: `i_Data` is presented.
- `i_Data`, input, 8: byte to send.
- `o_Ready`, output, 1: block can accept a byte (registered).
- `o_Tx`, output, 1: UART line, idle high (registered).
- `o_Busy`, output, 1: a frame is in progress (registered).
- `o_Done`, output, 1: one-cycle pulse when a frame completes.

## Operation
- States: `IDLE`, `START`, `DATA`, `PARITY`, `STOP`, `GAP`.
- **Accept:** a byte is accepted when `i_Valid` and `o_Ready` are both high at a rising `Clk` edge.
  - `i_Data` is latched into the shift register.
  - Odd or even parity is computed from the latched byte, not from live `i_Data`.
- **State flow:**
  - `IDLE` → `START` on accept.
  - `START` → `DATA` after one bit time.
  - `DATA` shifts out 8 bits, LSB first.
  - `DATA` → `PARITY` if `PARITY` ≠ 0, otherwise `DATA` → `STOP`.
  - `STOP` lasts `STOP_BITS` bit times, then → `GAP` (or → `IDLE` if `GAP_BITS` = 0).
  - `GAP` lasts `GAP_BITS` bit times, then → `IDLE`.
- **Bit timer:** counts 0 to `CLKS_PER_BIT`−1, then wraps.
  - Width is `$clog2(CLKS_PER_BIT)`.
  - A bit counter of 3 bits indexes the data bits and the stop/gap repetitions.
- **`i_Valid` while busy:** ignored, with no effect on the frame in flight. `i_Data` is don't-care outside an accept.
- **Reset:** asserting `i_Rst` at any time, mid-frame included, forces immediately:
  - state `IDLE`
  - `o_Tx` = 1, `o_Ready` = 1
  - `o_Busy` = 0, `o_Done` = 0
  - counters = 0
  
  The partial frame is abandoned. No byte is accepted while `i_Rst` is high.
- **Reset values:** `o_Tx` 1, `o_Ready` 1, `o_Busy` 0, `o_Done` 0.

## Timing
- Let C = `CLKS_PER_BIT`, P = 1 if `PARITY` ≠ 0 else 0, and F = (9 + P + `STOP_BITS` + `GAP_BITS`) × C.
- Accept at edge k. At that edge:
  - `o_Ready` → 0, `o_Busy` → 1
  - `o_Tx` → 0 (start bit)
- Line schedule:
  - Start bit is low from edge k to edge k+C.
  - Data bit i is driven from edge k+(1+i)C, for i = 0..7.
  - Parity bit, if enabled, is driven from edge k+9C.
  - Stop and gap bits are high.
- End of frame, at edge k+F:
  - state → `IDLE`
  - `o_Ready` → 1, `o_Busy` → 0
  - `o_Done` → 1 for exactly one cycle
- **Back-to-back transfers:** the earliest next accept is edge k+F+1.
  - The byte period is F+1 cycles.
  - The line stays high for that one extra cycle.
- `o_Tx` is glitch-free because it comes from a register only.

## Structure
- Shared package `uart_pkg` holds:
  - the state enum
  - the parity encodings (`PAR_NONE`, `PAR_ODD`, `PAR_EVEN`)
  - the default bit-rate constant for 125 MHz / 115200
- One sub-module, `uart_bit_timer`:
  - parameterised by `CLKS_PER_BIT`
  - inputs: `Clk`, `i_Rst`, `i_Run`
  - output: `o_Tick`, high on the last cycle of each bit time
  - clears whenever `i_Run` is low
- The top-level FSM and shift register stay in `uart_byte_tx`.

## Test plan
- **Reset:** hold `i_Rst` for 3 cycles, then release → `o_Tx` = 1, `o_Ready` = 1, `o_Busy` = 0, `o_Done` = 0, line stays high for 100 cycles.
- **Single byte:** C=4, no parity, 1 stop, 1 gap; send 0xA5 → line reads 0,1,0,1,0,0,1,0,1,1,1 at 4 cycles/bit; `o_Done` pulses at k+44; `o_Ready` rises at k+44.
- **Even parity:** C=4, `PARITY`=2, send 0x07 → parity bit = 1; odd-parity build sends 0.
- **Back-to-back:** hold `i_Valid` high with 0x00 then 0xFF → second start bit falls at k+F+1; both bytes are decoded correctly by a bench UART receiver.
- **Busy-time change:** change `i_Data` and toggle `i_Valid` mid-frame → transmitted byte is unchanged and no extra frame is sent.
- **Reset mid-frame:** assert `i_Rst` during data bit 3 → `o_Tx` = 1 at once, `o_Ready` = 1; the next byte 0x3C is sent cleanly afterwards.
